mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
MEM-stage data-memory access controller for the 16-bit pipeline. Takes the load/store request of the instruction currently in MEM (from the EX/MEM register). Drives a variable-latency data-memory request/acknowledge bus. Returns load data and a pipeline-wide stall_n, which feeds the MEM/WB register's wb_data_mem source and its stall_n input.

Parameters:
TIMEOUT, 15, max cycles spent waiting for dmem_ack before the access is abandoned (1..255)
ERR_DATA, 16'hFFFF, load data returned on a timed-out read

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
mem_MemRead  in  1  MEM-stage instruction is a load
mem_MemWrite  in  1  MEM-stage instruction is a store
mem_addr  in  16  byte address (EX ALU result)
mem_wdata  in  16  store data
dmem_req  out  1  request valid to data memory
dmem_we  out  1  1 = write, 0 = read; valid while dmem_req
dmem_addr  out  16  word address; mem_addr with bit 0 forced to 0
dmem_wdata  out  16  store data
dmem_ack  in  1  memory completed the request this cycle
dmem_rdata  in  16  read data; valid when dmem_ack and !dmem_we
mem_data_mem  out  16  registered load data, to MEM/WB data_mem input
stall_n  out  1  0 = hold all upstream pipeline registers and MEM/WB
bus_err  out  1  sticky: timeout or read+write conflict seen
misalign  out  1  combinational: access with mem_addr[0]=1

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - state=IDLE, wait counter=0, rdata_q=16'h0000, bus_err=0.
  - Therefore mem_data_mem=0, dmem_req=0, stall_n=1.
- access = mem_MemRead | mem_MemWrite.
- we = mem_MemWrite. If both are set, the write wins and bus_err is set.
- FSM states:
  - IDLE:
    - If access: dmem_req=1 and stall_n=0 (combinational, same cycle).
    - If dmem_ack is also 1 this cycle → DONE, else → WAIT.
    - If !access: dmem_req=0, stall_n=1, stay in IDLE.
  - WAIT:
    - dmem_req=1 and stall_n=0.
    - Counter increments each cycle.
    - dmem_ack → DONE.
    - If the counter reaches TIMEOUT with no ack: → DONE, bus_err set, rdata_q loaded with ERR_DATA (reads only).
  - DONE:
    - dmem_req=0 and stall_n=1, so the held instruction advances into MEM/WB at this edge.
    - Counter cleared, → IDLE unconditionally.
    - A request present in the next IDLE cycle belongs to the next instruction.
- Data capture: rdata_q <= dmem_rdata on the ack edge of a read only. Writes leave rdata_q unchanged. mem_data_mem = rdata_q.
- Request stability:
  - dmem_addr, dmem_we and dmem_wdata are driven from the inputs.
  - The inputs are frozen by stall_n=0, so they are stable from request start to ack.
- Latency:
  - Minimum access = 2 cycles (IDLE+ack, then DONE), i.e. 1 stall cycle.
  - General: stall cycles = cycles until ack; exit via DONE is always 1 cycle.
- Ignored acks: dmem_ack seen in DONE or in IDLE with !access has no effect.
- Reset mid-access: immediate return to IDLE. dmem_req drops asynchronously and the outstanding request is abandoned.
- bus_err: cleared only by reset.
- misalign: flags only; the access proceeds word-aligned.

Test Plan:
- Reset: assert rst_n=0 mid-WAIT → dmem_req=0, stall_n=1, mem_data_mem=0 immediately, without waiting for a clock edge.
- Load, zero-wait: mem_MemRead=1, addr=16'h0010, ack in the same cycle with rdata=16'hBEEF → stall_n low 1 cycle; DONE next cycle with stall_n=1 and mem_data_mem=16'hBEEF.
- Load, 3-cycle wait: ack 3 cycles after request with rdata=16'h1234 → stall_n=0 for 4 cycles; dmem_req held for the same span, address stable.
- Store: MemWrite=1, addr=16'h0021, wdata=16'h00AA, ack after 1 cycle → dmem_we=1, dmem_addr=16'h0020, misalign=1; mem_data_mem keeps its previous value.
- Timeout: read with no ack → after TIMEOUT=15 wait cycles, DONE; mem_data_mem=16'hFFFF, bus_err=1 and stays 1.
- Back-to-back: load then store in consecutive instructions → IDLE re-issues the request the cycle after DONE; no ack double-counted.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: issues load/store requests on a
// variable-latency req/ack bus, stalls the pipeline until the access completes,
// and returns registered load data to the MEM/WB register.
module mem_access_unit #(
    parameter int unsigned TIMEOUT  = 15,
    parameter logic [15:0] ERR_DATA = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_MemRead,
    input  logic        mem_MemWrite,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [15:0] dmem_rdata,
    output logic [15:0] mem_data_mem,
    output logic        stall_n,
    output logic        bus_err,
    output logic        misalign
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic [DATA_W-1:0]   r_rdata;
    logic [DATA_W-1:0]   w_rdata_nxt;
    logic                r_bus_err;
    logic                w_bus_err_nxt;
    logic                w_access;
    logic                w_conflict;
    logic                w_req;

    assign w_access   = mem_MemRead | mem_MemWrite;
    assign w_conflict = mem_MemRead & mem_MemWrite;
    assign w_cnt_inc  = r_cnt + CNT_W'(1);

    // State, wait counter, load data and sticky error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rdata   <= w_rdata_nxt;
            r_bus_err <= w_bus_err_nxt;
        end
    end

    // Next-state, counter, data capture and request generation
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_rdata_nxt   = r_rdata;
        w_bus_err_nxt = r_bus_err;
        w_req         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    w_req = 1'b1;
                    if (w_conflict) begin
                        w_bus_err_nxt = 1'b1;
                    end
                    if (dmem_ack) begin
                        if (!mem_MemWrite) begin
                            w_rdata_nxt = dmem_rdata;
                        end
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_req     = 1'b1;
                w_cnt_nxt = w_cnt_inc;
                if (w_conflict) begin
                    w_bus_err_nxt = 1'b1;
                end
                if (dmem_ack) begin
                    if (!mem_MemWrite) begin
                        w_rdata_nxt = dmem_rdata;
                    end
                    w_state_nxt = S_DONE;
                end else if (w_cnt_inc == CNT_W'(TIMEOUT)) begin
                    // Memory never answered: abandon the access and flag it
                    w_bus_err_nxt = 1'b1;
                    if (!mem_MemWrite) begin
                        w_rdata_nxt = ERR_DATA;
                    end
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Request is gated by reset so it drops without waiting for a clock edge
    assign dmem_req     = w_req & rst_n;
    assign stall_n      = ~dmem_req;
    assign dmem_we      = mem_MemWrite;
    assign dmem_addr    = {mem_addr[DATA_W-1:1], 1'b0};
    assign dmem_wdata   = mem_wdata;
    assign mem_data_mem = r_rdata;
    assign bus_err      = r_bus_err;
    assign misalign     = w_access & mem_addr[0];

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, hand-written
// corner sequences and randomized accesses against a transaction-level model.
module tb_mem_access_unit;

    localparam int unsigned TMO = 15;
    localparam logic [15:0] ERR = 16'hFFFF;

    logic        clk;
    logic        rst_n;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        ack;
    logic [15:0] rdata;
    logic [15:0] mem_data_mem;
    logic        stall_n;
    logic        bus_err;
    logic        misalign;

    int n_checks;
    int n_fail;

    mem_access_unit #(.TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_MemRead  (rd),
        .mem_MemWrite (wr),
        .mem_addr     (addr),
        .mem_wdata    (wdata),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (ack),
        .dmem_rdata   (rdata),
        .mem_data_mem (mem_data_mem),
        .stall_n      (stall_n),
        .bus_err      (bus_err),
        .misalign     (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          lat;
        logic [15:0] rdata;
        int          exp_stall;
        logic [15:0] exp_data;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One access: inputs held until DONE, ack raised 'lat' cycles after the
    // request; ack stays high with junk data afterwards to exercise ignored acks.
    task automatic run_access(input logic i_rd, input logic i_wr, input logic [15:0] i_addr,
                              input logic [15:0] i_wdata, input int lat,
                              input logic [15:0] i_rdata, output int stalls);
        logic [15:0] exp_addr;
        bit done;
        exp_addr = i_addr & 16'hFFFE;
        stalls   = 0;
        done     = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                rd = i_rd; wr = i_wr; addr = i_addr; wdata = i_wdata;
            end
            ack   = (c >= lat);
            rdata = (c == lat) ? i_rdata : ~i_rdata;
            #1;
            if (stall_n) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (c == 0) begin
                    check("req_we", dmem_we, i_wr);
                    check("req_wdata", dmem_wdata, i_wdata);
                    check("misalign", misalign, i_addr[0]);
                end
                check("req_held", dmem_req, 1'b1);
                check("req_addr", dmem_addr, exp_addr);
            end
        end
        if (!done) check("stall_bound", 32'd0, 32'd1);
        check("done_req", dmem_req, 1'b0);
    endtask

    // Cycles with no access and random acks on the bus
    task automatic idle(input int n, input logic [15:0] exp_data);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rd = 1'b0; wr = 1'b0;
            ack = 1'($urandom_range(0, 1));
            rdata = 16'($urandom);
            #1;
            check("idle_req", dmem_req, 1'b0);
            check("idle_stall_n", stall_n, 1'b1);
            check("idle_data", mem_data_mem, exp_data);
        end
    endtask

    initial begin
        int          stalls;
        int          kind;
        int          lat;
        logic        r_rd;
        logic        r_wr;
        logic [15:0] r_addr;
        logic [15:0] r_wdata;
        logic [15:0] r_rdata;
        logic [15:0] model_data;
        logic        model_err;
        int          exp_stall;
        bit          timed_out;

        n_checks = 0;
        n_fail   = 0;

        tbl[0] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 0, 16'hBEEF, 1, 16'hBEEF};
        tbl[1] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 3, 16'h1234, 4, 16'h1234};
        tbl[2] = '{1'b0, 1'b1, 16'h0021, 16'h00AA, 1, 16'h9999, 2, 16'h1234};
        tbl[3] = '{1'b1, 1'b0, 16'h0033, 16'h0000, 2, 16'h5A5A, 3, 16'h5A5A};
        tbl[4] = '{1'b0, 1'b1, 16'h0100, 16'hCAFE, 0, 16'h4444, 1, 16'h5A5A};

        rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; ack = 1'b0; rdata = '0;
        #1;
        check("rst_req", dmem_req, 1'b0);
        check("rst_stall_n", stall_n, 1'b1);
        check("rst_data", mem_data_mem, 16'h0000);
        check("rst_err", bus_err, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Directed vectors, issued back-to-back
        for (int i = 0; i < 5; i++) begin
            run_access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].lat,
                       tbl[i].rdata, stalls);
            check($sformatf("vec%0d_stalls", i), 32'(stalls), 32'(tbl[i].exp_stall));
            check($sformatf("vec%0d_data", i), mem_data_mem, tbl[i].exp_data);
            check($sformatf("vec%0d_err", i), bus_err, 1'b0);
        end
        idle(2, 16'h5A5A);

        // Ack on the last allowed wait cycle still completes normally
        run_access(1'b1, 1'b0, 16'h0200, 16'h0000, TMO, 16'h0F0F, stalls);
        check("lastack_stalls", 32'(stalls), 32'(TMO + 1));
        check("lastack_data", mem_data_mem, 16'h0F0F);
        check("lastack_err", bus_err, 1'b0);

        // Randomized accesses against a transaction-level model
        model_data = 16'h0F0F;
        model_err  = 1'b0;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            r_rd = (kind == 0) || (kind >= 5);
            r_wr = (kind <= 4);
            lat  = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 20) : $urandom_range(0, 4);
            r_addr  = 16'($urandom);
            r_wdata = 16'($urandom);
            r_rdata = 16'($urandom);
            timed_out = (lat > int'(TMO));
            exp_stall = timed_out ? int'(TMO) + 1 : lat + 1;
            if (r_rd && !r_wr) model_data = timed_out ? ERR : r_rdata;
            if (timed_out || (r_rd && r_wr)) model_err = 1'b1;
            run_access(r_rd, r_wr, r_addr, r_wdata, lat, r_rdata, stalls);
            check("rnd_stalls", 32'(stalls), 32'(exp_stall));
            check("rnd_data", mem_data_mem, model_data);
            check("rnd_err", bus_err, model_err);
            if ($urandom_range(0, 3) == 0) idle(1, model_data);
        end

        // Read that is never acknowledged
        run_access(1'b1, 1'b0, 16'h0300, 16'h0000, 1000, 16'h1111, stalls);
        check("tmo_stalls", 32'(stalls), 32'(TMO + 1));
        check("tmo_data", mem_data_mem, ERR);
        check("tmo_err", bus_err, 1'b1);
        idle(3, ERR);
        check("tmo_err_sticky", bus_err, 1'b1);

        // Asynchronous reset in the middle of a wait
        @(posedge clk); #1;
        rd = 1'b1; wr = 1'b0; addr = 16'h0050; ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midwait_req", dmem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_req", dmem_req, 1'b0);
        check("arst_stall_n", stall_n, 1'b1);
        check("arst_data", mem_data_mem, 16'h0000);
        check("arst_err", bus_err, 1'b0);
        rd = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        // Normal operation resumes after reset
        run_access(1'b1, 1'b0, 16'h0060, 16'h0000, 1, 16'hA5A5, stalls);
        check("post_rst_stalls", 32'(stalls), 32'd2);
        check("post_rst_data", mem_data_mem, 16'hA5A5);
        idle(1, 16'hA5A5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
